// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery exponentiation sequencer.
package mont_pkg;
  localparam int MONT_WIDTH = 1024;

  typedef enum logic [2:0] {IDLE, SQ, MUL, NEXT, FROM, DONE} exp_state_t;
  typedef enum logic [1:0] {CLR, GO, WAIT} mm_phase_t;

  localparam logic [MONT_WIDTH-1:0] MM_ONE = {{(MONT_WIDTH-1){1'b0}}, 1'b1};
endpackage

// File: rtl/mont_exp_bitcnt.sv
// Exponent walker: MSB-aligned shift register plus down-counter of remaining bits.
module mont_exp_bitcnt
  import mont_pkg::*;
#(
  parameter int EXP_WIDTH = 1024,
  parameter int LW        = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 step,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [LW-1:0]        elen,
  output logic                 cur_bit,
  output logic                 last_bit
);
  logic [EXP_WIDTH-1:0] sh;
  logic [LW-1:0]        cnt;

  // Left-align bit elen-1 so the current bit is always the MSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= e << (LW'(EXP_WIDTH) - elen);
      cnt <= elen - 1'b1;
    end else if (step) begin
      sh  <= sh << 1;
      cnt <= cnt - 1'b1;
    end
  end

  assign cur_bit  = sh[EXP_WIDTH-1];
  assign last_bit = (cnt == '0);
endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Macro MONT_EXP_CONST_TIME_EN: run MUL for every exponent bit (dummy product to scratch).
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int  WIDTH     = MONT_WIDTH,
  parameter int  EXP_WIDTH = 1024,
  localparam int LW        = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LW-1:0]        in_elen,
  input  logic [WIDTH-1:0]     in_m,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_clr_n,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);
`ifdef MONT_EXP_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
  logic [WIDTH-1:0] scratch;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  exp_state_t       st;
  mm_phase_t        ph;
  logic [WIDTH-1:0] xr, acc, one_w;
  logic             cur_bit, last_bit;

  assign one_w = MM_ONE[WIDTH-1:0];

  mont_exp_bitcnt #(.EXP_WIDTH(EXP_WIDTH), .LW(LW)) u_bitcnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     ((st == IDLE) && start),
    .step     ((st == NEXT) && !last_bit),
    .e        (in_e),
    .elen     (in_elen),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  // Every op launch drops mm_clr_n for one cycle with operands already on mm_a/mm_b,
  // since the multiplier holds done until it is cleared.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= IDLE;
      ph       <= CLR;
      xr       <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      mm_start <= 1'b0;
      mm_clr_n <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
`ifdef MONT_EXP_CONST_TIME_EN
      scratch  <= '0;
`endif
    end else begin
      done     <= 1'b0;
      mm_start <= 1'b0;
      mm_clr_n <= 1'b1;
      case (st)
        IDLE: if (start) begin
          xr       <= in_x;
          acc      <= in_r;
          mm_m     <= in_m;
          busy     <= 1'b1;
          ph       <= CLR;
          mm_clr_n <= 1'b0;
          mm_a     <= in_r;
          if (in_elen == '0) begin
            st   <= FROM;
            mm_b <= one_w;
          end else begin
            st   <= SQ;
            mm_b <= in_r;
          end
        end
        SQ, MUL, FROM: begin
          case (ph)
            CLR: begin
              mm_start <= 1'b1;
              ph       <= GO;
            end
            GO: ph <= WAIT;
            default: if (mm_done) begin
              ph <= CLR;
              if (st == SQ) begin
                acc <= mm_result;
                if (cur_bit || CONST_TIME) begin
                  st       <= MUL;
                  mm_clr_n <= 1'b0;
                  mm_a     <= mm_result;
                  mm_b     <= xr;
                end else begin
                  st <= NEXT;
                end
              end else if (st == MUL) begin
`ifdef MONT_EXP_CONST_TIME_EN
                if (cur_bit) acc <= mm_result;
                else         scratch <= mm_result;
`else
                acc <= mm_result;
`endif
                st <= NEXT;
              end else begin
                acc <= mm_result;
                st  <= DONE;
              end
            end
          endcase
        end
        NEXT: begin
          ph       <= CLR;
          mm_clr_n <= 1'b0;
          mm_a     <= acc;
          if (last_bit) begin
            st   <= FROM;
            mm_b <= one_w;
          end else begin
            st   <= SQ;
            mm_b <= acc;
          end
        end
        DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench: 8-bit behavioural Montgomery multiplier plus modular-power reference.
module tb_mont_exp_ctrl;
  localparam int W  = 8;
  localparam int EW = 8;
  localparam int LW = $clog2(EW + 1);
`ifdef MONT_EXP_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0, resetn = 1'b1, start = 1'b0;
  logic [W-1:0]  in_x = '0, in_r = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [LW-1:0] in_elen = '0;
  logic [W-1:0]  result, mm_a, mm_b, mm_m;
  logic          done, busy, mm_clr_n, mm_start;
  logic [W-1:0]  mm_result = '0, mm_pend = '0;
  logic          mm_done = 1'b0;
  int            mm_cnt = 0;

  int checks = 0, errors = 0;
  bit run_active = 0, op_live = 0;
  int exp_res = 0, exp_ops = 0, n_ops = 0, n_done = 0, last_res = 0;
  logic prev_clr = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_x(in_x), .in_r(in_r),
    .in_e(in_e), .in_elen(in_elen), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .mm_clr_n(mm_clr_n), .mm_start(mm_start), .mm_a(mm_a),
    .mm_b(mm_b), .mm_m(mm_m), .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // a*b*R^-1 mod m, R = 256, by search.
  function automatic int mont(int a, int b, int m);
    if (m == 0) return 0;
    for (int t = 0; t < m; t++)
      if ((t * 256) % m == (a * b) % m) return t;
    return 0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiplier: cleared by mm_clr_n, random latency, done held high.
  always @(posedge clk or negedge mm_clr_n) begin
    if (!mm_clr_n) begin
      mm_done <= 1'b0;
      mm_cnt  <= 0;
    end else if (mm_start) begin
      mm_pend   <= W'(mont(int'(mm_a), int'(mm_b), int'(mm_m)));
      mm_result <= W'($urandom);
      mm_cnt    <= $urandom_range(1, 4);
    end else if (mm_cnt != 0) begin
      mm_cnt <= mm_cnt - 1;
      if (mm_cnt == 1) begin
        mm_done   <= 1'b1;
        mm_result <= mm_pend;
      end
    end
  end

  // Compare process.
  always @(negedge clk) if (resetn) begin
    if (mm_start) begin
      n_ops++;
      chk("clr_before_start", int'({prev_clr, mm_clr_n}), 1);
      op_a = mm_a; op_b = mm_b; op_live = 1;
    end
    if (mm_done && op_live) begin
      chk("operand_a_stable", int'(mm_a), int'(op_a));
      chk("operand_b_stable", int'(mm_b), int'(op_b));
      op_live = 0;
    end
    prev_clr = mm_clr_n;
    if (done) begin
      chk("done_expected", int'(run_active), 1);
      chk("result", int'(result), exp_res);
      chk("op_count", n_ops, exp_ops);
      chk("busy_at_done", int'(busy), 0);
      n_done++;
      last_res = exp_res;
      run_active = 0;
    end else begin
      chk("busy", int'(busy), int'(run_active));
      if (!run_active) chk("result_held", int'(result), last_res);
    end
  end

  task automatic launch(int xn, int e, int elen, int m);
    int ev, acc;
    ev  = e & ((1 << elen) - 1);
    acc = 1 % m;
    repeat (ev) acc = (acc * xn) % m;
    exp_res = acc;
    exp_ops = CT ? 2 * elen + 1 : elen + $countones(ev) + 1;
    in_m = W'(m); in_r = W'(256 % m); in_x = W'((xn * 256) % m);
    in_e = EW'(e); in_elen = LW'(elen);
    n_ops = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_active = 1;
    // Scramble inputs: the design must work from its latched copies.
    in_x = W'($urandom); in_r = W'($urandom); in_m = W'($urandom | 1);
    in_e = EW'($urandom); in_elen = LW'($urandom_range(0, EW));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (!run_active) return;
    end
    checks++; errors++;
    $display("FAIL done_timeout: no done within 3000 cycles, required one");
    run_active = 0;
  endtask

  initial begin
    int d0, m;
    #1 resetn = 1'b0;
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mm_start", int'(mm_start), 0);
    chk("rst_mm_clr_n", int'(mm_clr_n), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mm_a", int'(mm_a), 0);
    chk("rst_mm_m", int'(mm_m), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // 2^5 mod 13 = 6
    launch(2, 5, 3, 13);
    chk("t1_model", exp_res, 6);
    wait_done();
    chk("t1_result", int'(result), 6);
    chk("t1_ops", n_ops, CT ? 7 : 6);

    // elen = 0 -> 1 after a single op
    launch(7, 'hA5, 0, 13);
    wait_done();
    chk("t2_result", int'(result), 1);
    chk("t2_ops", n_ops, 1);

    // 2^255 mod 251 = 2^5 = 32 (Fermat)
    launch(2, 'hFF, 8, 251);
    wait_done();
    chk("t3_result", int'(result), 32);
    chk("t3_ops", n_ops, 17);

    // second start while busy is ignored
    d0 = n_done;
    launch(3, 'hB7, 8, 241);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; in_elen = LW'(1);
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    chk("t4_one_done", n_done - d0, 1);

    // reset during WAIT of op 3
    launch(5, 'h6, 3, 199);
    for (int k = 0; k < 2000 && n_ops < 3; k++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    chk("t5_done", int'(done), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_mm_start", int'(mm_start), 0);
    chk("t5_mm_clr_n", int'(mm_clr_n), 0);
    run_active = 0; op_live = 0; last_res = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    launch(5, 'h6, 3, 199);
    wait_done();

    // randomized runs
    for (int n = 0; n < 40; n++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      launch(int'($urandom % m), int'($urandom_range(0, 255)), int'($urandom_range(0, EW)), m);
      wait_done();
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
